// File: rtl/sd_buf_pkg.sv
// Shared widths and helpers for the SD block ring buffer.
// Derived widths below describe the default configuration; modules
// recompute them from their own parameters.
package sd_buf_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_BLOCK_WORDS = 128;
    localparam int DEF_NUM_BLOCKS  = 2;

    localparam int WORD_AW = $clog2(DEF_BLOCK_WORDS);
    localparam int BLK_AW  = $clog2(DEF_NUM_BLOCKS);
    localparam int CNT_W   = BLK_AW + 1;
    localparam int STRB_W  = DEF_DATA_WIDTH / 8;

    // Advance a block pointer by one, wrapping modulo a power-of-2 ring size.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned num);
        return (ptr + 32'd1) & (num - 32'd1);
    endfunction

endpackage

// File: rtl/sd_buf_ram.sv
// True dual-port RAM, per-port read/write enables, byte-strobe writes and
// read-first registered outputs. Storage itself is never reset.
module sd_buf_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_a_re,
    input  logic                    i_a_we,
    input  logic [DATA_WIDTH/8-1:0] i_a_strb,
    input  logic [ADDR_W-1:0]       i_a_addr,
    input  logic [DATA_WIDTH-1:0]   i_a_wdata,
    output logic [DATA_WIDTH-1:0]   o_a_rdata,
    input  logic                    i_b_re,
    input  logic                    i_b_we,
    input  logic [DATA_WIDTH/8-1:0] i_b_strb,
    input  logic [ADDR_W-1:0]       i_b_addr,
    input  logic [DATA_WIDTH-1:0]   i_b_wdata,
    output logic [DATA_WIDTH-1:0]   o_b_rdata
);

    localparam int SW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;

    // Byte-lane writes from both ports; the two ports never share a block.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < SW; b++) begin
            if (i_a_we && i_a_strb[b]) r_mem[i_a_addr][b*8 +: 8] <= i_a_wdata[b*8 +: 8];
            if (i_b_we && i_b_strb[b]) r_mem[i_b_addr][b*8 +: 8] <= i_b_wdata[b*8 +: 8];
        end
    end

    // Registered reads see the pre-write word (read-first) and hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (i_a_re) r_a_rdata <= r_mem[i_a_addr];
            if (i_b_re) r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/sd_block_buf.sv
// Block ring buffer between the SD controller (producer) and CPU (consumer).
// Holds block pointers, occupancy count, access gating and the sticky error.
// Optional macro SD_BUF_BYTE_STROBE_EN: when defined, write strobes are
// honoured per byte; otherwise every effective write updates the full word.
module sd_block_buf
    import sd_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int NUM_BLOCKS  = DEF_NUM_BLOCKS
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            p_ren,
    input  logic                            p_wen,
    input  logic [DATA_WIDTH/8-1:0]         p_wstrb,
    input  logic [$clog2(BLOCK_WORDS)-1:0]  p_addr,
    input  logic [DATA_WIDTH-1:0]           p_wdata,
    output logic [DATA_WIDTH-1:0]           p_rdata,
    input  logic                            p_commit,
    output logic                            p_ready,
    input  logic                            c_ren,
    input  logic                            c_wen,
    input  logic [DATA_WIDTH/8-1:0]         c_wstrb,
    input  logic [$clog2(BLOCK_WORDS)-1:0]  c_addr,
    input  logic [DATA_WIDTH-1:0]           c_wdata,
    output logic [DATA_WIDTH-1:0]           c_rdata,
    input  logic                            c_release,
    output logic                            c_valid,
    output logic [$clog2(NUM_BLOCKS):0]     count,
    output logic                            err
);

    localparam int AW = $clog2(BLOCK_WORDS);
    localparam int BW = $clog2(NUM_BLOCKS);
    localparam int CW = BW + 1;
    localparam int SW = DATA_WIDTH / 8;

    logic [BW-1:0] r_wr_ptr;
    logic [BW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic          w_p_ready;
    logic          w_c_valid;
    logic          w_commit_ok;
    logic          w_release_ok;
    logic [SW-1:0] w_p_strb;
    logic [SW-1:0] w_c_strb;

    assign w_p_ready    = (r_count != CW'(NUM_BLOCKS));
    assign w_c_valid    = (r_count != '0);
    assign w_commit_ok  = p_commit  & w_p_ready;
    assign w_release_ok = c_release & w_c_valid;

`ifdef SD_BUF_BYTE_STROBE_EN
    assign w_p_strb = p_wstrb;
    assign w_c_strb = c_wstrb;
`else
    // Strobe ports stay on the interface but every write is full-word.
    logic w_unused_strb;
    assign w_unused_strb = ^{p_wstrb, c_wstrb};
    assign w_p_strb = '1;
    assign w_c_strb = '1;
`endif

    // Ownership bookkeeping; commit/release are judged on pre-cycle flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_commit_ok)  r_wr_ptr <= BW'(ptr_inc(32'(r_wr_ptr), NUM_BLOCKS));
            if (w_release_ok) r_rd_ptr <= BW'(ptr_inc(32'(r_rd_ptr), NUM_BLOCKS));
            case ({w_commit_ok, w_release_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_err <= r_err | (p_commit & ~w_p_ready) | (c_release & ~w_c_valid);
        end
    end

    // Accesses use the pointers as they stand before any same-cycle handover.
    sd_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (BW + AW)
    ) u_ram (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_a_re    (p_ren & w_p_ready),
        .i_a_we    (p_wen & w_p_ready),
        .i_a_strb  (w_p_strb),
        .i_a_addr  ({r_wr_ptr, p_addr}),
        .i_a_wdata (p_wdata),
        .o_a_rdata (p_rdata),
        .i_b_re    (c_ren & w_c_valid),
        .i_b_we    (c_wen & w_c_valid),
        .i_b_strb  (w_c_strb),
        .i_b_addr  ({r_rd_ptr, c_addr}),
        .i_b_wdata (c_wdata),
        .o_b_rdata (c_rdata)
    );

    assign p_ready = w_p_ready;
    assign c_valid = w_c_valid;
    assign count   = r_count;
    assign err     = r_err;

endmodule
